// File: rtl/fft_xbar_pkg.sv
// Shared types, constants and source-index helpers for the FFT stage crossbar.
// The index helpers answer: which input word lands on output word j for stage s.
package fft_xbar_pkg;

  localparam int FFT_BIT_WIDTH = 32;
  localparam int FFT_SIZE      = 8;

  typedef struct packed {
    logic [FFT_SIZE-1:0][FFT_BIT_WIDTH-1:0] re;
    logic [FFT_SIZE-1:0][FFT_BIT_WIDTH-1:0] im;
  } frame_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pairing order: within each 2H group, output 2k/2k+1 come from k and k+H.
  function automatic int front_index(input int j, input int s);
    int h, g, r;
    h = 1 << s;
    g = j - (j % (2 * h));
    r = j - g;
    return g + (r >> 1) + ((r % 2) * h);
  endfunction

  function automatic int back_index(input int j, input int s);
    int h, g, r;
    h = 1 << s;
    g = j - (j % (2 * h));
    r = j - g;
    return (r < h) ? (g + 2 * r) : (g + 2 * (r - h) + 1);
  endfunction

endpackage

// File: rtl/fft_stage_crossbar_pipe_if.sv
// Frame handshake bundle between two butterfly stages; slave is the crossbar side.
interface fft_stage_crossbar_pipe_if
  import fft_xbar_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int SIZE_FFT  = FFT_SIZE,
  parameter int STAGE_W   = $clog2($clog2(SIZE_FFT)) + 1
);

  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] recv_real;
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] recv_imaginary;
  logic [STAGE_W-1:0]                 recv_stage;
  logic                               recv_front;
  logic                               recv_val;
  logic                               recv_rdy;
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] send_real;
  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] send_imaginary;
  logic                               send_val;
  logic                               send_rdy;
  logic                               cfg_err;

  modport slave (
    input  recv_real, recv_imaginary, recv_stage, recv_front, recv_val, send_rdy,
    output recv_rdy, send_real, send_imaginary, send_val, cfg_err
  );

  modport master (
    output recv_real, recv_imaginary, recv_stage, recv_front, recv_val, send_rdy,
    input  recv_rdy, send_real, send_imaginary, send_val, cfg_err
  );

endinterface

// File: rtl/fft_xbar_permute.sv
// Combinational butterfly-pair reorder: one precomputed mapping per legal stage,
// selected at runtime; illegal stages fall through to identity and raise stage_bad.
module fft_xbar_permute
  import fft_xbar_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int SIZE_FFT  = FFT_SIZE,
  parameter int STAGE_W   = $clog2($clog2(SIZE_FFT)) + 1
) (
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] src_real,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] src_imaginary,
  input  logic [STAGE_W-1:0]                 stage,
  input  logic                               front,
  output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] perm_real,
  output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] perm_imaginary,
  output logic                               stage_bad
);

  localparam int LOG2  = log2_ceil(SIZE_FFT);
  localparam int SEL_W = $clog2(LOG2 + 1);

  logic [SEL_W-1:0] sel;

  // Slot LOG2 of each candidate vector holds the identity word.
  assign stage_bad = (stage >= STAGE_W'(LOG2));
  assign sel       = stage_bad ? SEL_W'(LOG2) : SEL_W'(stage);

  for (genvar j = 0; j < SIZE_FFT; j++) begin : g_word
    logic [LOG2:0][BIT_WIDTH-1:0] cand_real;
    logic [LOG2:0][BIT_WIDTH-1:0] cand_imaginary;

    for (genvar st = 0; st < LOG2; st++) begin : g_stage
      localparam int FI = front_index(j, st);
      localparam int BI = back_index(j, st);
      assign cand_real[st]      = front ? src_real[FI]      : src_real[BI];
      assign cand_imaginary[st] = front ? src_imaginary[FI] : src_imaginary[BI];
    end

    assign cand_real[LOG2]      = src_real[j];
    assign cand_imaginary[LOG2] = src_imaginary[j];
    assign perm_real[j]         = cand_real[sel];
    assign perm_imaginary[j]    = cand_imaginary[sel];
  end

endmodule

// File: rtl/fft_stage_crossbar_pipe.sv
// Registered stage crossbar: permutes on enqueue into a 2-entry frame buffer so each
// frame carries its own stage/direction and the output side is a plain head read.
module fft_stage_crossbar_pipe
  import fft_xbar_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int SIZE_FFT  = FFT_SIZE,
  parameter int STAGE_W   = $clog2($clog2(SIZE_FFT)) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  fft_stage_crossbar_pipe_if.slave bus
);

  typedef logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] word_vec_t;

  word_vec_t  perm_real;
  word_vec_t  perm_imaginary;
  word_vec_t  buf_real      [2];
  word_vec_t  buf_imaginary [2];
  logic       stage_bad;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       enq;
  logic       deq;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       recv_rdy_q;
  logic       send_val_q;
  logic       cfg_err_q;

  fft_xbar_permute #(
    .BIT_WIDTH (BIT_WIDTH),
    .SIZE_FFT  (SIZE_FFT),
    .STAGE_W   (STAGE_W)
  ) u_permute (
    .src_real       (bus.recv_real),
    .src_imaginary  (bus.recv_imaginary),
    .stage          (bus.recv_stage),
    .front          (bus.recv_front),
    .perm_real      (perm_real),
    .perm_imaginary (perm_imaginary),
    .stage_bad      (stage_bad)
  );

  assign enq = bus.recv_val && recv_rdy_q;
  assign deq = send_val_q && bus.send_rdy;

  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + 2'd1;
    end else if (deq && !enq) begin
      count_next = count - 2'd1;
    end
  end

  // Flags are derived from the next count so they are registered yet never a cycle stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      count      <= count_next;
      recv_rdy_q <= (count_next < 2'd2);
      send_val_q <= (count_next != 2'd0);
      if (enq) begin
        wr_ptr <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      if (enq && stage_bad) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Frame storage needs no reset; only the pointers and count define its validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_real[wr_ptr]      <= perm_real;
      buf_imaginary[wr_ptr] <= perm_imaginary;
    end
  end

  assign bus.recv_rdy       = recv_rdy_q;
  assign bus.send_val       = send_val_q;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.send_real      = buf_real[rd_ptr];
  assign bus.send_imaginary = buf_imaginary[rd_ptr];

endmodule

// File: doc/fft_stage_crossbar_pipe.md
Name: fft_stage_crossbar_pipe

Overview:
- Registered, runtime-configurable butterfly-reordering crossbar for the pipelined FFT datapath.
- Sits between consecutive butterfly stages. Permutes a full SIZE_FFT-point complex frame into or out of adjacent butterfly-pair order for a stage selected per frame.
- Carries one val/rdy handshake per frame and decouples the stages with a 2-entry frame buffer.
- Replaces per-stage, hard-wired combinational crossbars: one instance serves any stage and either direction.

Parameters:
- BIT_WIDTH, 32, width of each real and imaginary word.
- SIZE_FFT, 8, points per frame; power of two, >= 2.
- STAGE_W, $clog2($clog2(SIZE_FFT))+1, width of stage_sel.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- recv_real  input  BIT_WIDTH x SIZE_FFT  incoming real words, index 0..SIZE_FFT-1.
- recv_imaginary  input  BIT_WIDTH x SIZE_FFT  incoming imaginary words.
- recv_stage  input  STAGE_W  FFT stage s for this frame.
- recv_front  input  1  1 = front (pairing) mapping, 0 = back (un-pairing) mapping.
- recv_val  input  1  frame valid.
- recv_rdy  output  1  block can accept a frame.
- send_real  output  BIT_WIDTH x SIZE_FFT  permuted real words.
- send_imaginary  output  BIT_WIDTH x SIZE_FFT  permuted imaginary words.
- send_val  output  1  output frame valid.
- send_rdy  input  1  downstream accepts a frame.
- cfg_err  output  1  sticky flag: a frame was accepted with an out-of-range stage.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: buffer count = 0, read/write pointers = 0, cfg_err = 0, send_val = 0, recv_rdy = 1 after reset deasserts. Buffer data contents are don't-care, but send_* words must be driven from entry 0 (no X-gating required).
- Permutation: let H = 2^s, and let g range over multiples of 2H below SIZE_FFT, with k in 0..H-1.
  - Front: out[g+2k] = in[g+k]; out[g+2k+1] = in[g+k+H].
  - Back (exact inverse): out[g+k] = in[g+2k]; out[g+k+H] = in[g+2k+1].
  - Real and imaginary use the same mapping.
- Valid stage range: s in 0..log2(SIZE_FFT)-1.
  - s >= log2(SIZE_FFT): frame passes as identity, and cfg_err sets on acceptance.
  - cfg_err clears only on reset.
- The permutation is applied on the enqueue side. Stage and direction are sampled with the frame, so every frame may use a different configuration with no idle cycles.
- Handshake: a transfer occurs when val && rdy in the same cycle.
  - recv_rdy = (count < 2). It is registered and has no combinational path from send_rdy.
  - send_val = (count > 0). send_* shows the head entry.
  - Output stays stable while send_val && !send_rdy.
- Latency: a frame accepted in cycle t is presented on send_* with send_val in cycle t+1.
- Throughput: one frame per cycle while downstream is ready.
- Count update:
  - enqueue only: +1.
  - dequeue only: -1.
  - both in the same cycle (count == 1): count unchanged, and pointers advance independently.
  - When count == 2, recv_rdy = 0, so no enqueue can coincide with full.
- Pointers are 1 bit each and wrap 1 -> 0.
- Reset mid-operation: buffered frames are discarded immediately (asynchronous), and send_val drops in the same cycle.

Decomposition:
- Package fft_xbar_pkg holds:
  - a log2 constant helper;
  - the frame struct {real[], imaginary[]} typedef;
  - a function front_index(j, s) / back_index(j, s) returning the source index.
- Sub-module fft_xbar_permute (combinational, parametrised by BIT_WIDTH and SIZE_FFT) applies the mapping from the stage/front inputs.
- The top level contains the 2-entry buffer, pointers, count and cfg_err.

Test Plan:
- SIZE_FFT=8, data in[j]=j, stage 1, front -> out 0,2,1,3,4,6,5,7 in cycle t+1. Imaginary words carry 100+j and show the same order.
- Stage 2 front -> 0,4,1,5,2,6,3,7. Stage 2 back -> 0,2,4,6,1,3,5,7. Stage 0 in either direction -> identity.
- Back-to-back frames with stage 1 front, then stage 2 back, with send_rdy=1 -> one output per cycle, each permuted with its own configuration.
- send_rdy=0 while sending 3 frames -> recv_rdy drops after 2 acceptances and the third is held at the source. The head stays stable. Raising send_rdy drains frames 1 and 2 in order, then the third is accepted.
- count==1 with simultaneous enqueue and dequeue for 10 cycles -> count stays 1 and there is no loss or duplication, checked by a scoreboard.
- stage 5 on SIZE_FFT=8 -> identity output and cfg_err=1 from the next cycle, persisting. Reset asserted mid-burst -> send_val=0 and cfg_err=0 immediately, and recv_rdy=1 after release.
